// File: rtl/seq_bypass_mult_if.sv
// -----------------------------------------------------------------------------
// seq_bypass_mult_if
//
// Purpose:
//   Groups the operand handshake, the result handshake and the status line of
//   the sequential row-bypass multiplier into a single bundle. The clock and
//   the reset are not part of the bundle; they stay plain ports on the block.
//
// Parameters:
//   WIDTH      operand width in bits (product is 2*WIDTH bits)
//
// Signals:
//   in_valid   master -> slave   operands a/b valid
//   in_ready   slave  -> master  block can accept operands
//   a          master -> slave   multiplicand, WIDTH bits
//   b          master -> slave   multiplier, WIDTH bits
//   out_valid  slave  -> master  pro and add_count valid
//   out_ready  master -> slave   consumer accepts result
//   pro        slave  -> master  product a*b, 2*WIDTH bits
//   add_count  slave  -> master  rows where the adder was engaged, CW bits
//   busy       slave  -> master  high while a multiplication is in flight
//
// Modports:
//   master     the side that supplies operands and consumes results
//   slave      the multiplier itself
// -----------------------------------------------------------------------------
interface seq_bypass_mult_if #(
    parameter int WIDTH = 4
);

    localparam int CW = $clog2(WIDTH + 1);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   pro;
    logic [CW-1:0]        add_count;
    logic                 busy;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  pro,
        input  add_count,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output pro,
        output add_count,
        output busy
    );

endinterface

// File: rtl/seq_bypass_mult.sv
// -----------------------------------------------------------------------------
// seq_bypass_mult
//
// Purpose:
//   WIDTH x WIDTH unsigned sequential multiplier. One partial-product row is
//   handled per clock. When the current multiplier bit is 0 the row is
//   bypassed: the accumulator keeps its value and only the row position
//   advances. The number of rows that actually went through the adder is
//   reported alongside the product.
//
//   Operation:
//     IDLE  -> accept a/b on in_valid, clear accumulator and counters
//     CALC  -> one row per edge, rows 0 .. WIDTH-1
//     DONE  -> hold pro/add_count with out_valid high until out_ready
//   Requests are never overlapped: in_ready is only high in IDLE, and a
//   request presented in the same cycle that DONE is acknowledged is not
//   taken until the block is back in IDLE.
//
// Parameters:
//   WIDTH      operand width, 2..32; product width is 2*WIDTH
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, aborts any operation in flight
//   bus        seq_bypass_mult_if.slave (in_valid/in_ready/a/b,
//              out_valid/out_ready/pro/add_count, busy)
//
// Build option:
//   SEQ_BYPASS_MULT_ZERO_SKIP_EN
//     When defined, CALC terminates as soon as no set multiplier bits remain,
//     giving a latency of msb_index(b)+1 cycles, and b==0 goes straight from
//     IDLE to DONE on the accept edge. When undefined, latency is always
//     WIDTH cycles. pro and add_count are the same in both builds.
// -----------------------------------------------------------------------------
module seq_bypass_mult #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_bypass_mult_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    row;

    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_next;
    logic [WIDTH-1:0] mplier_next;
    logic             last_row;

    // Row datapath. The multiplicand is zero-extended to the full product
    // width before shifting so no bits are lost on the upper rows. The adder
    // result is only selected when the multiplier LSB is set; otherwise the
    // accumulator passes straight through (bypassed row).
    always_comb begin
        addend      = {{WIDTH{1'b0}}, mcand} << row;
        acc_next    = mplier[0] ? (acc + addend) : acc;
        mplier_next = mplier >> 1;
`ifdef SEQ_BYPASS_MULT_ZERO_SKIP_EN
        // Stop as soon as the remaining multiplier is empty; the final row
        // check is kept so termination never depends on data alone.
        last_row    = (mplier_next == '0) || (row == CW'(WIDTH - 1));
`else
        last_row    = (row == CW'(WIDTH - 1));
`endif
    end

    // Control FSM with registered status outputs. in_ready, out_valid and
    // busy are written together with the state so they always equal their
    // state decode (IDLE, DONE and not-IDLE respectively) without any
    // combinational path from state to the ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mcand         <= '0;
            mplier        <= '0;
            acc           <= '0;
            row           <= '0;
            bus.pro       <= '0;
            bus.add_count <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand         <= bus.a;
                        mplier        <= bus.b;
                        acc           <= '0;
                        row           <= '0;
                        bus.add_count <= '0;
                        bus.in_ready  <= 1'b0;
                        bus.busy      <= 1'b1;
`ifdef SEQ_BYPASS_MULT_ZERO_SKIP_EN
                        // Nothing to add for a zero multiplier: the result is
                        // known on the accept edge.
                        if (bus.b == '0) begin
                            bus.pro       <= '0;
                            bus.out_valid <= 1'b1;
                            state         <= DONE;
                        end else begin
                            state         <= CALC;
                        end
`else
                        state         <= CALC;
`endif
                    end
                end

                CALC: begin
                    acc    <= acc_next;
                    mplier <= mplier_next;
                    row    <= row + CW'(1);
                    if (mplier[0]) begin
                        bus.add_count <= bus.add_count + CW'(1);
                    end
                    if (last_row) begin
                        bus.pro       <= acc_next;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end

                DONE: begin
                    // pro is left as-is on the way out; it only carries
                    // meaning while out_valid is high.
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bypass_mult.sv
// -----------------------------------------------------------------------------
// tb_seq_bypass_mult
//
// Directed bench for seq_bypass_mult. Two instances are exercised: WIDTH=4
// for the handshake, bypass, backpressure and reset scenarios, and WIDTH=8
// for the wide corner case and a batch of random operand pairs. Expected
// latencies follow the build option SEQ_BYPASS_MULT_ZERO_SKIP_EN.
// -----------------------------------------------------------------------------
module tb_seq_bypass_mult;

    logic clk;
    logic rst_n;

    int checks = 0;
    int passes = 0;

    seq_bypass_mult_if #(.WIDTH(4)) bus4 ();
    seq_bypass_mult_if #(.WIDTH(8)) bus8 ();

    seq_bypass_mult #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    seq_bypass_mult #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles from the accept edge until out_valid is seen, for this build.
    function automatic int exp_lat(input int bv, input int w);
        int msb1;
        msb1 = 0;
        for (int i = 0; i < w; i++) begin
            if (bv[i]) msb1 = i + 1;
        end
`ifdef SEQ_BYPASS_MULT_ZERO_SKIP_EN
        return msb1;
`else
        return (msb1 >= 0) ? w : 0;
`endif
    endfunction

    // Present one operand pair to the 4-bit instance and wait (bounded) for
    // out_valid. Returns -1 as latency if the result never appears.
    task automatic run4(input logic [3:0] av, input logic [3:0] bv,
                        output int lat, output logic [7:0] p, output logic [2:0] c);
        bus4.a         = av;
        bus4.b         = bv;
        bus4.in_valid  = 1'b1;
        bus4.out_ready = 1'b0;
        @(posedge clk); #1;
        bus4.in_valid  = 1'b0;
        lat = 0;
        while (bus4.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus4.out_valid !== 1'b1) lat = -1;
        p = bus4.pro;
        c = bus4.add_count;
    endtask

    task automatic ack4();
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output logic [15:0] p, output logic [3:0] c);
        bus8.a         = av;
        bus8.b         = bv;
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b0;
        @(posedge clk); #1;
        bus8.in_valid  = 1'b0;
        lat = 0;
        while (bus8.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus8.out_valid !== 1'b1) lat = -1;
        p = bus8.pro;
        c = bus8.add_count;
    endtask

    task automatic ack8();
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus4.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", bus4.in_ready); else passes++;
        checks++; if (bus4.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", bus4.out_valid); else passes++;
        checks++; if (bus4.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus4.busy); else passes++;
        checks++; if (bus4.pro !== 8'd0) $display("[TB] FAIL reset_pro: got %0d expected 0", bus4.pro); else passes++;
        checks++; if (bus4.add_count !== 3'd0) $display("[TB] FAIL reset_add_count: got %0d expected 0", bus4.add_count); else passes++;
        checks++; if (bus8.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready8: got %b expected 1", bus8.in_ready); else passes++;
    endtask

    task automatic test_full_ones();
        int lat; logic [7:0] p; logic [2:0] c;
        run4(4'd15, 4'd15, lat, p, c);
        checks++; if (lat != exp_lat(15, 4)) $display("[TB] FAIL ones_latency: got %0d expected %0d", lat, exp_lat(15, 4)); else passes++;
        checks++; if (p !== 8'd225) $display("[TB] FAIL ones_pro: got %0d expected 225", p); else passes++;
        checks++; if (c !== 3'd4) $display("[TB] FAIL ones_add_count: got %0d expected 4", c); else passes++;
        ack4();
        checks++; if (bus4.in_ready !== 1'b1) $display("[TB] FAIL ones_in_ready_after_ack: got %b expected 1", bus4.in_ready); else passes++;
        checks++; if (bus4.out_valid !== 1'b0) $display("[TB] FAIL ones_out_valid_after_ack: got %b expected 0", bus4.out_valid); else passes++;
    endtask

    task automatic test_bypass();
        logic [7:0] acc_exp [4];
        acc_exp[0] = 8'd12; acc_exp[1] = 8'd12; acc_exp[2] = 8'd60; acc_exp[3] = 8'd60;
        bus4.a = 4'd12; bus4.b = 4'd5; bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++; if (dut4.acc !== acc_exp[k]) $display("[TB] FAIL bypass_acc_row%0d: got %0d expected %0d", k, dut4.acc, acc_exp[k]); else passes++;
        end
        checks++; if (bus4.out_valid !== 1'b1) $display("[TB] FAIL bypass_out_valid: got %b expected 1", bus4.out_valid); else passes++;
        checks++; if (bus4.pro !== 8'd60) $display("[TB] FAIL bypass_pro: got %0d expected 60", bus4.pro); else passes++;
        checks++; if (bus4.add_count !== 3'd2) $display("[TB] FAIL bypass_add_count: got %0d expected 2", bus4.add_count); else passes++;
        ack4();
        begin
            int lat; logic [7:0] p; logic [2:0] c;
            run4(4'd12, 4'd5, lat, p, c);
            checks++; if (lat != exp_lat(5, 4)) $display("[TB] FAIL bypass_latency: got %0d expected %0d", lat, exp_lat(5, 4)); else passes++;
            ack4();
        end
    endtask

    task automatic test_zero();
        int lat; logic [7:0] p; logic [2:0] c;
        run4(4'd10, 4'd0, lat, p, c);
        checks++; if (lat != exp_lat(0, 4)) $display("[TB] FAIL zero_b_latency: got %0d expected %0d", lat, exp_lat(0, 4)); else passes++;
        checks++; if (p !== 8'd0) $display("[TB] FAIL zero_b_pro: got %0d expected 0", p); else passes++;
        checks++; if (c !== 3'd0) $display("[TB] FAIL zero_b_add_count: got %0d expected 0", c); else passes++;
        ack4();
        run4(4'd14, 4'd3, lat, p, c);
        checks++; if (lat != exp_lat(3, 4)) $display("[TB] FAIL short_b_latency: got %0d expected %0d", lat, exp_lat(3, 4)); else passes++;
        checks++; if (p !== 8'd42) $display("[TB] FAIL short_b_pro: got %0d expected 42", p); else passes++;
        checks++; if (c !== 3'd2) $display("[TB] FAIL short_b_add_count: got %0d expected 2", c); else passes++;
        ack4();
        run4(4'd0, 4'd13, lat, p, c);
        checks++; if (p !== 8'd0) $display("[TB] FAIL zero_a_pro: got %0d expected 0", p); else passes++;
        checks++; if (c !== 3'd3) $display("[TB] FAIL zero_a_add_count: got %0d expected 3", c); else passes++;
        ack4();
    endtask

    task automatic test_backpressure();
        int lat; logic [7:0] p; logic [2:0] c;
        run4(4'd9, 4'd6, lat, p, c);
        checks++; if (p !== 8'd54) $display("[TB] FAIL bp_pro: got %0d expected 54", p); else passes++;
        checks++; if (c !== 3'd2) $display("[TB] FAIL bp_add_count: got %0d expected 2", c); else passes++;
        for (int i = 0; i < 6; i++) begin
            bus4.in_valid = 1'b1;
            bus4.a = (i % 2 == 0) ? 4'd5 : 4'd11;
            bus4.b = (i % 2 == 0) ? 4'd15 : 4'd1;
            @(posedge clk); #1;
            checks++; if (bus4.pro !== 8'd54) $display("[TB] FAIL bp_pro_hold%0d: got %0d expected 54", i, bus4.pro); else passes++;
            checks++; if (bus4.in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready%0d: got %b expected 0", i, bus4.in_ready); else passes++;
            checks++; if (bus4.out_valid !== 1'b1) $display("[TB] FAIL bp_out_valid%0d: got %b expected 1", i, bus4.out_valid); else passes++;
        end
        // Acknowledge with a request pending: must go IDLE without accepting.
        bus4.a = 4'd3; bus4.b = 4'd5; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.out_ready = 1'b0;
        checks++; if (bus4.out_valid !== 1'b0) $display("[TB] FAIL bp_ack_out_valid: got %b expected 0", bus4.out_valid); else passes++;
        checks++; if (bus4.busy !== 1'b0) $display("[TB] FAIL bp_ack_not_accepted: got busy %b expected 0", bus4.busy); else passes++;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        checks++; if (bus4.busy !== 1'b1) $display("[TB] FAIL bp_next_accepted: got busy %b expected 1", bus4.busy); else passes++;
        lat = 0;
        while (bus4.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (bus4.pro !== 8'd15 || bus4.out_valid !== 1'b1) $display("[TB] FAIL bp_next_pro: got %0d (valid %b) expected 15", bus4.pro, bus4.out_valid); else passes++;
        ack4();
    endtask

    task automatic test_reset_mid();
        int lat; logic [7:0] p; logic [2:0] c;
        bus4.a = 4'd15; bus4.b = 4'd8; bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (bus4.out_valid !== 1'b0) $display("[TB] FAIL rst_mid_no_early_valid: got %b expected 0", bus4.out_valid); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if (bus4.in_ready !== 1'b1) $display("[TB] FAIL rst_mid_in_ready: got %b expected 1", bus4.in_ready); else passes++;
        checks++; if (bus4.busy !== 1'b0) $display("[TB] FAIL rst_mid_busy: got %b expected 0", bus4.busy); else passes++;
        checks++; if (bus4.pro !== 8'd0) $display("[TB] FAIL rst_mid_pro: got %0d expected 0", bus4.pro); else passes++;
        checks++; if (bus4.add_count !== 3'd0) $display("[TB] FAIL rst_mid_add_count: got %0d expected 0", bus4.add_count); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        bus4.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (bus4.out_valid !== 1'b0) $display("[TB] FAIL rst_mid_no_valid%0d: got %b expected 0", i, bus4.out_valid); else passes++;
        end
        run4(4'd7, 4'd8, lat, p, c);
        checks++; if (lat != exp_lat(8, 4)) $display("[TB] FAIL rst_next_latency: got %0d expected %0d", lat, exp_lat(8, 4)); else passes++;
        checks++; if (p !== 8'd56) $display("[TB] FAIL rst_next_pro: got %0d expected 56", p); else passes++;
        checks++; if (c !== 3'd1) $display("[TB] FAIL rst_next_add_count: got %0d expected 1", c); else passes++;
        ack4();
    endtask

    task automatic test_width8();
        int lat; logic [15:0] p; logic [3:0] c;
        int av; int bv;
        run8(8'd255, 8'd255, lat, p, c);
        checks++; if (lat != exp_lat(255, 8)) $display("[TB] FAIL w8_max_latency: got %0d expected %0d", lat, exp_lat(255, 8)); else passes++;
        checks++; if (p !== 16'd65025) $display("[TB] FAIL w8_max_pro: got %0d expected 65025", p); else passes++;
        checks++; if (c !== 4'd8) $display("[TB] FAIL w8_max_add_count: got %0d expected 8", c); else passes++;
        ack8();
        for (int n = 0; n < 200; n++) begin
            av = int'($urandom_range(0, 255));
            bv = int'($urandom_range(0, 255));
            run8(av[7:0], bv[7:0], lat, p, c);
            checks++; if (p !== 16'(av * bv)) $display("[TB] FAIL w8_rand_pro: %0d*%0d got %0d expected %0d", av, bv, p, av * bv); else passes++;
            checks++; if (c !== 4'($countones(bv[7:0]))) $display("[TB] FAIL w8_rand_add_count: b=%0d got %0d expected %0d", bv, c, $countones(bv[7:0])); else passes++;
            checks++; if (lat != exp_lat(bv, 8)) $display("[TB] FAIL w8_rand_latency: b=%0d got %0d expected %0d", bv, lat, exp_lat(bv, 8)); else passes++;
            ack8();
        end
    endtask

    // Test sequence: hold reset for two edges, then run each scenario.
    initial begin
        rst_n = 1'b0;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b0;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_full_ones();
        test_bypass();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_width8();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/seq_bypass_mult.md
Name: seq_bypass_mult

Overview:
- Parametrised sequential multiplier: WIDTH x WIDTH unsigned, one partial-product row per clock, with a valid/ready handshake on both input and output.
- Row bypass: when a multiplier bit is 0, the adder is not engaged for that row. Only the accumulator's row position advances.
- Successor to the team's 4x4 combinational row-bypass multiplier. Intended for datapaths where area matters more than single-cycle latency.

Parameters:
- WIDTH, 4, operand width in bits. Legal range 2..32. Product width is 2*WIDTH.
- CW, $clog2(WIDTH+1), width of the row and add counters. Derived; not overridden by instantiators.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands a/b valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  multiplicand
- b  in  WIDTH  multiplier
- out_valid  out  1  pro and add_count valid
- out_ready  in  1  consumer accepts result
- pro  out  2*WIDTH  product a*b
- add_count  out  CW  number of rows where the adder was engaged (popcount of processed b bits)
- busy  out  1  high in CALC or DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - pro, add_count, internal accumulator, shift registers and row counter all 0.
  - out_valid=0, busy=0.
  - in_ready=1, since it is decoded from state.
- Outputs are decoded from state: in_ready = (state==IDLE); out_valid = (state==DONE); busy = !IDLE.
- IDLE, on in_valid (accept edge E):
  - latch a into the multiplicand register and b into the multiplier shift register.
  - clear acc (2*WIDTH bits), row counter and add_count.
  - go to CALC.
- CALC, each edge processes row k = row counter:
  - if mplier[0]=1: acc <= acc + (zero-extended a << k); add_count++.
  - else: bypass, acc unchanged.
  - mplier >>= 1; k++.
  - after row WIDTH-1: pro <= final acc; go to DONE.
- Latency: DONE is entered at edge E+WIDTH, so out_valid is high after that edge. Fixed regardless of data.
- DONE:
  - pro and add_count held stable while out_ready=0.
  - on out_ready=1, go to IDLE. pro keeps its last value; it is only meaningful while out_valid=1.
- No overlap. in_ready=0 in CALC and DONE. in_valid in those states is ignored and operands are not sampled.
- Simultaneous events: in DONE with out_ready=1 and in_valid=1, the block returns to IDLE and does not accept. A new operand pair is accepted no earlier than the next edge. Result throughput is at most one per WIDTH+2 cycles.
- Arithmetic: no overflow is possible. Max product (2^WIDTH-1)^2 fits in 2*WIDTH bits; acc must be 2*WIDTH wide.
- Reset mid-operation: rst_n low in any state aborts immediately to reset values. The partial result is discarded and no out_valid pulse occurs.
- a=0 or b=0: product is 0. add_count = popcount(b) for a=0; add_count = 0 for b=0.

Optional Feature:
- Macro: SEQ_BYPASS_MULT_ZERO_SKIP_EN.
- Defined (early termination):
  - in CALC, if the multiplier remaining after the current shift is 0, load pro and go to DONE on that edge.
  - latency L = msb_index(b)+1.
  - if b==0 at acceptance, go IDLE->DONE on edge E with pro=0 and add_count=0, so out_valid is high right after E (L=0).
- Undefined: fixed latency WIDTH for all operands, as above.
- pro and add_count values are identical in both builds; only latency differs.

Test Plan:
- WIDTH=4, a=15, b=15, out_ready=1 -> out_valid after E+4, pro=225, add_count=4; in_ready returns 1 one cycle later.
- WIDTH=4, a=12, b=5 -> pro=60, add_count=2; rows 1 and 3 bypassed (acc unchanged on those edges); latency 4.
- WIDTH=4, a=10, b=0 -> pro=0, add_count=0.
  - Without macro: latency 4.
  - With macro: out_valid right after E.
  - With macro, a=14, b=3 -> pro=42, latency 2.
- Backpressure: a=9, b=6, out_ready held 0 for 6 cycles with in_valid=1 and a/b toggling -> pro=54 held, in_ready=0, no new operands sampled. out_ready=1 -> IDLE, then next pair accepted.
- Reset mid-CALC: a=15, b=8, rst_n pulled low 2 cycles after E -> immediate IDLE, pro=0, out_valid never asserts. Next a=7, b=8 gives pro=56.
- WIDTH=8: a=255, b=255 -> pro=65025, add_count=8, latency 8. Then random 200 pairs vs reference model a*b.
